spi_xfer_sched: RTL and testbench
=================================

// Module: spi_xfer_sched
// PURPOSE
// - Multi-byte transaction scheduler for the shared 8-bit SPI byte engine (spi_byte_if side below).
// - Arbitrates NREQ requesters round-robin, drives per-requester slave select, sequences load/unload
//   per byte, streams TX bytes in and RX bytes out. Sits between client IPs and the engine instance.
// PARAMETERS
// - NREQ      2    number of requesters / slave selects (2..8)
// - LEN_W     4    width of per-requester byte count (max burst 2**LEN_W-1)
// - TIMEOUT   31   engine watchdog limit in clock_in cycles (used only with SPI_SCHED_TIMEOUT_EN)
// PORTS
// - clock_in     in   1          system/SPI clock
// - reset        in   1          asynchronous, active-high
// - req          in   NREQ       level request per requester
// - req_len      in   NREQ*LEN_W byte count, requester i at [i*LEN_W +: LEN_W], sampled at grant
// - tx_data      in   NREQ*8     next TX byte per requester, sampled when tx_take pulses
// - gnt          out  NREQ       one-hot grant, held for whole transaction
// - cs_n         out  NREQ       active-low slave select, low bit = granted requester
// - tx_take      out  1          1-cycle pulse: granted requester's tx_data consumed
// - rx_data      out  8          received byte, valid with rx_valid
// - rx_valid     out  1          1-cycle pulse per received byte
// - done         out  NREQ       1-cycle pulse to requester at end of its transaction
// - err          out  1          1-cycle pulse on watchdog abort (0 when macro off)
// - eng_load     out  1          engine load strobe
// - eng_datain   out  8          engine parallel TX byte
// - eng_unload   out  1          engine capture strobe
// - eng_dataout  in   8          engine parallel RX byte
// - eng_ssn_out  in   1          engine busy indicator, low while shifting
// BEHAVIOUR
// - Reset: state IDLE; gnt=0, cs_n=all 1, tx_take=rx_valid=eng_load=eng_unload=err=0, done=0,
//   rx_data=eng_datain=8'h00, rr pointer=0, remaining count=0. Reset mid-transaction aborts
//   immediately; no done pulse.
// - FSM: IDLE -> GRANT -> LOAD -> WAIT_LO -> SHIFT -> UNLOAD -> (LOAD | FIN) -> IDLE.
// - IDLE: if any req, pick first set bit at or after rr pointer (wrap); go GRANT.
// - GRANT: gnt one-hot set, latch req_len into remaining; len==0 -> FIN without cs_n/engine activity;
//   else cs_n[i]=0 and go LOAD. cs_n stays low until FIN.
// - LOAD (1 cycle): eng_load=1, eng_datain=tx_data[i], tx_take=1, remaining-=1.
// - WAIT_LO: wait eng_ssn_out==0; SHIFT: wait eng_ssn_out==1.
// - UNLOAD (1 cycle): eng_unload=1, rx_data<=eng_dataout, rx_valid pulses next cycle;
//   remaining!=0 -> LOAD, else FIN.
// - FIN (1 cycle): done[i]=1, gnt=0, cs_n=all 1, rr pointer = i+1 mod NREQ; -> IDLE.
// - Grant latency req->gnt: 1 cycle from IDLE; min 1 idle cycle between transactions.
// - req deassert mid-transaction ignored; transaction runs to its latched count.
// - Simultaneous reqs: strict round-robin, no starvation; new reqs during a transaction wait.
// - Bytes per transaction arbitrary in 1..2**LEN_W-1; remaining never wraps below 0.
// CONFIGURATION
// - SPI_SCHED_TIMEOUT_EN defined: cycle counter runs in WAIT_LO/SHIFT, cleared on state entry;
//   reaching TIMEOUT -> err pulse, done[i] pulse, cs_n all 1, gnt=0, -> IDLE, rr advances.
// - Undefined: no counter; FSM waits indefinitely; err tied 0.
// STRUCTURE
// - Package spi_sched_pkg: state enum (IDLE,GRANT,LOAD,WAIT_LO,SHIFT,UNLOAD,FIN), localparams
//   for state encoding widths.
// - Sub-module spi_rr_arb: NREQ round-robin picker (req, ptr -> one-hot, index, any).
// - Top instantiates spi_rr_arb plus FSM, byte counter, optional watchdog.
// TESTING
// - Single req0 len=3, tx 8'hA5,8'h3C,8'hFF, engine model loops back -> 3 tx_take, rx_valid with
//   A5,3C,FF, cs_n=2'b10 throughout, one done[0].
// - req=2'b11 held, len=1 each -> grants 0 then 1 then 0 (alternating), never same twice in row.
// - len=0 on req1 -> gnt[1] 1 cycle path, done[1] pulse, eng_load never asserted, cs_n stays 2'b11.
// - reset asserted during SHIFT of byte 2 of 4 -> all outputs reset values next edge, no done.
// - Macro on, engine holds eng_ssn_out=0 forever, TIMEOUT=31 -> err+done pulse 31 cycles after
//   SHIFT entry; next req granted normally. Macro off -> FSM remains in SHIFT.
// - req deasserted after grant, len=2 -> both bytes transferred, done pulse issued.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// Shared types for the SPI transaction scheduler: FSM state encoding and its width.
// No logic, no latency.
// Imported by spi_xfer_sched.
package spi_sched_pkg;

  localparam int STATE_W    = 3;
  localparam int NUM_STATES = 7;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    LOAD    = 3'd2,
    WAIT_LO = 3'd3,
    SHIFT   = 3'd4,
    UNLOAD  = 3'd5,
    FIN     = 3'd6
  } state_t;

endpackage

// File: rtl/spi_rr_arb.sv
// Round-robin picker: first set request at or after the pointer, wrapping at NREQ.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to sample the result.
module spi_rr_arb #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_idx    = IDX_W'(j);
        o_gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Multi-byte SPI transaction scheduler: round-robin grant, per-byte load/unload of the byte engine.
// Grant 1 cycle after req in IDLE; rx_valid 1 cycle after the unload strobe.
// Waits on eng_ssn_out; SPI_SCHED_TIMEOUT_EN adds a watchdog that aborts a stuck engine wait.
module spi_xfer_sched
  import spi_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ*8-1:0]     tx_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       cs_n,
  output logic                  tx_take,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  eng_load,
  output logic [7:0]            eng_datain,
  output logic                  eng_unload,
  input  logic [7:0]            eng_dataout,
  input  logic                  eng_ssn_out
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || LEN_W < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("spi_xfer_sched: parameter out of range");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [NREQ-1:0]  r_gnt_oh;
  logic [LEN_W-1:0] r_rem;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;

  logic [NREQ-1:0]  w_arb_gnt;
  logic [IDX_W-1:0] w_arb_idx;
  logic             w_arb_any;
  logic [IDX_W-1:0] w_idx_inc;
  logic [LEN_W-1:0] w_len;
  logic             w_waiting;
  logic             w_timeout;

  spi_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  assign w_idx_inc = (int'(r_idx) == NREQ - 1) ? '0 : r_idx + 1'b1;
  assign w_len     = req_len[int'(r_idx)*LEN_W +: LEN_W];
  // True while the engine handshake we are waiting for has not happened yet.
  assign w_waiting = ((r_state == WAIT_LO) &&  eng_ssn_out) ||
                     ((r_state == SHIFT)   && !eng_ssn_out);

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wd;

  // Watchdog: counts cycles stalled in a wait state, restarts on every state change.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset)                        r_wd <= '0;
    else if (w_state_nxt != r_state)  r_wd <= '0;
    else if (w_waiting)               r_wd <= r_wd + 1'b1;
  end

  assign w_timeout = w_waiting && (r_wd == WD_W'(TIMEOUT));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and per-state strobes; the engine/select outputs are decoded from state.
  always_comb begin
    w_state_nxt = r_state;
    gnt         = '0;
    cs_n        = '1;
    tx_take     = 1'b0;
    eng_load    = 1'b0;
    eng_unload  = 1'b0;
    eng_datain  = 8'h00;
    done        = '0;
    err         = w_timeout;
    case (r_state)
      IDLE: begin
        if (w_arb_any) w_state_nxt = GRANT;
      end
      GRANT: begin
        gnt         = r_gnt_oh;
        w_state_nxt = (w_len == '0) ? FIN : LOAD;
      end
      LOAD: begin
        gnt         = r_gnt_oh;
        cs_n        = ~r_gnt_oh;
        tx_take     = 1'b1;
        eng_load    = 1'b1;
        eng_datain  = tx_data[int'(r_idx)*8 +: 8];
        w_state_nxt = WAIT_LO;
      end
      WAIT_LO, SHIFT: begin
        if (w_timeout) begin
          done        = r_gnt_oh;
          w_state_nxt = IDLE;
        end else begin
          gnt  = r_gnt_oh;
          cs_n = ~r_gnt_oh;
          if (!w_waiting) w_state_nxt = (r_state == WAIT_LO) ? SHIFT : UNLOAD;
        end
      end
      UNLOAD: begin
        gnt         = r_gnt_oh;
        cs_n        = ~r_gnt_oh;
        eng_unload  = 1'b1;
        w_state_nxt = (r_rem != '0) ? LOAD : FIN;
      end
      FIN: begin
        done        = r_gnt_oh;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant capture, byte countdown, RX capture and round-robin pointer update.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_gnt_oh   <= '0;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= (r_state == UNLOAD);
      case (r_state)
        IDLE: begin
          if (w_arb_any) begin
            r_idx    <= w_arb_idx;
            r_gnt_oh <= w_arb_gnt;
          end
        end
        GRANT:  r_rem <= w_len;
        LOAD:   if (r_rem != '0) r_rem <= r_rem - 1'b1;
        UNLOAD: r_rx_data <= eng_dataout;
        FIN:    r_ptr <= w_idx_inc;
        default: ;
      endcase
      if (w_timeout) begin
        r_ptr <= w_idx_inc;
        r_rem <= '0;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Self-checking bench for spi_xfer_sched: table of transaction scenarios, random scenarios
// against a transaction-level round-robin model, plus reset-mid-transfer and stuck-engine sequences.
// Engine is a loopback model stepped from the same process that samples the DUT.
module tb_spi_xfer_sched;

  localparam int NREQ  = 2;
  localparam int LEN_W = 4;

  logic                  clock_in = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ*8-1:0]     tx_data;
  logic [NREQ-1:0]       gnt, cs_n, done;
  logic                  tx_take, rx_valid, err, eng_load, eng_unload;
  logic [7:0]            rx_data, eng_datain, eng_dataout;
  logic                  eng_ssn_out;

  spi_xfer_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .TIMEOUT(31)) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .req         (req),
    .req_len     (req_len),
    .tx_data     (tx_data),
    .gnt         (gnt),
    .cs_n        (cs_n),
    .tx_take     (tx_take),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .done        (done),
    .err         (err),
    .eng_load    (eng_load),
    .eng_datain  (eng_datain),
    .eng_unload  (eng_unload),
    .eng_dataout (eng_dataout),
    .eng_ssn_out (eng_ssn_out)
  );

  always #5 clock_in = ~clock_in;

  int n_vec = 0;
  int n_bad = 0;

  // sampled DUT outputs
  logic [NREQ-1:0] s_gnt, s_cs, s_done;
  logic            s_take, s_rxv, s_err, s_load;
  logic [7:0]      s_rx, s_datain;

  // stimulus byte queues per requester, engine model state, round-robin model pointer
  logic [7:0] txq0[$];
  logic [7:0] txq1[$];
  logic [7:0] eng_sh;
  int         eng_cnt;
  bit         eng_stuck;
  int         m_ptr;
  int         last_lat;

  typedef struct {
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    int         n;
    int         exp_first;
    bit         drop;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_tx();
    tx_data[7:0]  = (txq0.size() > 0) ? txq0[0] : 8'h00;
    tx_data[15:8] = (txq1.size() > 0) ? txq1[0] : 8'h00;
  endtask

  task automatic top_up();
    while (txq0.size() < 20) txq0.push_back(8'($urandom));
    while (txq1.size() < 20) txq1.push_back(8'($urandom));
    drive_tx();
  endtask

  // One clock: sample outputs mid-cycle, then advance the TX source and the engine model.
  task automatic tick();
    logic [7:0] tmp;
    @(negedge clock_in);
    s_gnt = gnt; s_cs = cs_n; s_done = done; s_take = tx_take; s_rxv = rx_valid;
    s_err = err; s_load = eng_load; s_rx = rx_data; s_datain = eng_datain;
    if (s_take && s_gnt[0] && txq0.size() > 0) tmp = txq0.pop_front();
    if (s_take && s_gnt[1] && txq1.size() > 0) tmp = txq1.pop_front();
    if (reset) begin
      eng_ssn_out = 1'b1;
    end else if (s_load) begin
      eng_sh      = s_datain;
      eng_cnt     = 1 + int'($urandom % 4);
      eng_ssn_out = 1'b0;
    end else if (!eng_ssn_out && !eng_stuck) begin
      if (eng_cnt == 0) begin
        eng_ssn_out = 1'b1;
        eng_dataout = eng_sh;
      end else begin
        eng_cnt--;
      end
    end
    drive_tx();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " gnt"},        gnt, 0);
    check({tag, " cs_n"},       cs_n, 2'b11);
    check({tag, " tx_take"},    tx_take, 0);
    check({tag, " rx_valid"},   rx_valid, 0);
    check({tag, " rx_data"},    rx_data, 0);
    check({tag, " done"},       done, 0);
    check({tag, " err"},        err, 0);
    check({tag, " eng_load"},   eng_load, 0);
    check({tag, " eng_unload"}, eng_unload, 0);
    check({tag, " eng_datain"}, eng_datain, 0);
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return 0;
  endfunction

  // Follow one transaction from grant to done and compare it with the expected outcome.
  task automatic run_xfer(input int exp_idx, input int exp_len, input bit drop_req, input string tag);
    logic [7:0]      exp_b[$];
    logic [7:0]      got_b[$];
    logic [NREQ-1:0] oh;
    int              takes, loads, cyc, nb;
    bit              seen, cs_low, cs_bad, gnt_bad;
    oh = '0;
    oh[exp_idx] = 1'b1;
    for (int b = 0; b < exp_len; b++) exp_b.push_back(exp_idx == 0 ? txq0[b] : txq1[b]);
    seen = 0;
    last_lat = 0;
    for (cyc = 0; cyc < 20 && !seen; cyc++) begin
      tick();
      last_lat++;
      if (s_gnt != 0) seen = 1;
    end
    check({tag, " grant seen"}, 32'(seen), 1);
    if (!seen) return;
    check({tag, " grant latency"}, last_lat, 1);
    check({tag, " gnt"}, s_gnt, oh);
    if (drop_req) req = '0;
    takes = 0; loads = 0; cs_low = 0; cs_bad = 0; gnt_bad = 0; seen = 0;
    for (cyc = 0; cyc < 3000 && !seen; cyc++) begin
      tick();
      if (s_take) takes++;
      if (s_load) loads++;
      if (s_rxv) got_b.push_back(s_rx);
      if (s_cs != 2'b11) begin
        cs_low = 1;
        if (s_cs != ~oh) cs_bad = 1;
      end
      if (s_done == 0 && s_gnt != oh) gnt_bad = 1;
      if (s_done != 0) seen = 1;
    end
    check({tag, " done seen"}, 32'(seen), 1);
    if (!seen) return;
    check({tag, " done"}, s_done, oh);
    check({tag, " gnt at done"}, s_gnt, 0);
    check({tag, " err"}, s_err, 0);
    check({tag, " tx_take count"}, takes, exp_len);
    check({tag, " eng_load count"}, loads, exp_len);
    check({tag, " cs_n asserted"}, 32'(cs_low), (exp_len > 0) ? 1 : 0);
    check({tag, " cs_n shape"}, 32'(cs_bad), 0);
    check({tag, " gnt held"}, 32'(gnt_bad), 0);
    check({tag, " rx count"}, got_b.size(), exp_len);
    nb = (got_b.size() < exp_len) ? got_b.size() : exp_len;
    for (int b = 0; b < nb; b++) check({tag, " rx byte"}, got_b[b], exp_b[b]);
    tick();
    check({tag, " idle gap"}, {s_gnt, s_done}, 0);
    m_ptr = (exp_idx + 1) % NREQ;
  endtask

  task automatic run_case(input logic [1:0] mask, input logic [3:0] l0, input logic [3:0] l1,
                          input int n, input int exp_first, input bit drop, input string tag);
    int idx;
    req_len = {l1, l0};
    req     = mask;
    for (int t = 0; t < n; t++) begin
      top_up();
      idx = (t == 0 && exp_first >= 0) ? exp_first : model_pick(mask);
      run_xfer(idx, (idx == 0) ? int'(l0) : int'(l1), drop, tag);
    end
    req = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "time limit");
  end

  initial begin
    int  at;
    int  takes;
    bit  any_done;
    reset = 1'b1; req = '0; req_len = '0; tx_data = '0;
    eng_ssn_out = 1'b1; eng_dataout = 8'h00; eng_sh = 8'h00; eng_cnt = 0; eng_stuck = 0;
    m_ptr = 0;
    tick(); tick();
    check_reset_outputs("reset held");
    reset = 1'b0;
    tick();
    check_reset_outputs("after reset");

    tbl[0] = '{2'b01, 4'd3,  4'd0, 1, 0, 1'b0};
    tbl[1] = '{2'b10, 4'd0,  4'd0, 1, 1, 1'b0};
    tbl[2] = '{2'b11, 4'd1,  4'd1, 4, 0, 1'b0};
    tbl[3] = '{2'b01, 4'd2,  4'd0, 1, 0, 1'b1};
    tbl[4] = '{2'b11, 4'd15, 4'd2, 3, 1, 1'b0};

    txq0.push_back(8'hA5); txq0.push_back(8'h3C); txq0.push_back(8'hFF);
    for (int v = 0; v < 5; v++)
      run_case(tbl[v].req, tbl[v].len0, tbl[v].len1, tbl[v].n, tbl[v].exp_first, tbl[v].drop,
               $sformatf("tbl%0d", v));

    for (int r = 0; r < 25; r++) begin
      logic [1:0] mask;
      logic [3:0] l0, l1;
      int         n;
      mask = 2'(1 + $urandom % 3);
      l0   = ($urandom % 5 == 0) ? 4'd0 : 4'($urandom);
      l1   = ($urandom % 5 == 0) ? 4'd0 : 4'($urandom);
      n    = 1 + int'($urandom % 3);
      run_case(mask, l0, l1, n, -1, (n == 1) && ($urandom % 3 == 0), $sformatf("rnd%0d", r));
    end

    // Reset during SHIFT of byte 2 of 4.
    top_up();
    req_len = {4'd0, 4'd4};
    req     = 2'b01;
    takes   = 0;
    for (int c = 0; c < 300 && takes < 2; c++) begin
      tick();
      if (s_take) takes++;
    end
    check("reset test second take", takes, 2);
    tick(); tick();
    reset = 1'b1;
    #1;
    check_reset_outputs("async reset");
    req = '0;
    any_done = 0;
    tick(); if (s_done != 0) any_done = 1;
    tick(); if (s_done != 0) any_done = 1;
    reset = 1'b0;
    m_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (s_done != 0 || s_gnt != 0) any_done = 1;
    end
    check("no done after reset abort", 32'(any_done), 0);
    run_case(2'b11, 4'd2, 4'd3, 2, 0, 1'b0, "post reset");

    // Engine that never finishes shifting.
    top_up();
    eng_stuck = 1;
    req_len = {4'd0, 4'd1};
    req     = 2'b01;
    at      = 0;
    for (int c = 0; c < 50 && at == 0; c++) begin
      tick();
      if (s_load) at = 1;
    end
    check("stuck test load seen", at, 1);
`ifdef SPI_SCHED_TIMEOUT_EN
    at = -1;
    for (int c = 1; c <= 40 && at < 0; c++) begin
      tick();
      if (s_err) begin
        at  = c;
        req = '0;
        check("timeout done", s_done, 2'b01);
        check("timeout gnt", s_gnt, 0);
        check("timeout cs_n", s_cs, 2'b11);
      end
    end
    check("timeout latency", at, 33);
    eng_stuck = 0;
    eng_ssn_out = 1'b1;
    m_ptr = 1;
`else
    any_done = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (s_done != 0 || s_err) any_done = 1;
    end
    check("stuck no done/err", 32'(any_done), 0);
    check("stuck gnt held", s_gnt, 2'b01);
    check("stuck cs_n held", s_cs, 2'b10);
    eng_stuck = 0;
    reset = 1'b1;
    req = '0;
    tick();
    reset = 1'b0;
    m_ptr = 0;
`endif
    tick();
    run_case(2'b11, 4'd2, 4'd2, 2, -1, 1'b0, "after stuck");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
